// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, addresses the
// instruction memory, buffers {pc, instr} pairs in a small queue and hands
// them to decode over a valid/ready handshake. Redirects flush the queue
// and restart fetch at the new target.

package riscky_pkg;
    localparam int XLEN       = 32;
    localparam int ILEN       = 32;
    localparam int IMEM_AW    = 10;
    localparam int IMEM_WORDS = 1 << IMEM_AW;
endpackage

module fetch_unit
    import riscky_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [ILEN-1:0]    imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [ILEN-1:0]    if_instr,
    output logic [XLEN-1:0]    if_pc
);

    localparam int              PW         = $clog2(QDEPTH);
    localparam logic [PW:0]     DEPTH      = (PW+1)'(QDEPTH);
    localparam logic [PW:0]     CNT_ONE    = (PW+1)'(1);
    localparam logic [PW-1:0]   PTR_ONE    = PW'(1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] q_pc    [QDEPTH];
    logic [ILEN-1:0] q_instr [QDEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_target;

    // The memory address comes straight from the PC register; upper PC bits
    // are simply truncated so the index wraps with the PC.
    assign imem_addr = pc[IMEM_AW+1:2];

    // Redirect targets are word aligned by masking off the low two bits.
    assign redirect_target = redirect_pc & ALIGN_MASK;

    // Handshake decisions: a pop frees a slot in the same cycle, so a full
    // queue can still accept a new fetch while decode is draining it.
    always_comb begin
        pop  = if_valid & if_ready;
        push = fetch_en & ~redirect_valid & ((count < DEPTH) | pop);
    end

    // PC, queue pointers, occupancy and entry storage. Reset wins over a
    // redirect, and a redirect wins over normal push/pop traffic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc     <= redirect_target;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_pc[wr_ptr]    <= pc;
                q_instr[wr_ptr] <= imem_rdata;
                wr_ptr          <= wr_ptr + PTR_ONE;
                pc              <= pc + PC_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Head presentation: everything here is derived from registers only, and
    // the data is forced to zero whenever the queue is empty.
    always_comb begin
        if_valid = (count != '0);
        if_instr = '0;
        if_pc    = '0;
        if (count != '0) begin
            if_instr = q_instr[rd_ptr];
            if_pc    = q_pc[rd_ptr];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for fetch_unit. Expected deliveries are
// queued as stimulus is issued; a negedge monitor pops and compares them
// whenever decode completes a handshake.

module tb_fetch_unit;
    import riscky_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               fetch_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [ILEN-1:0]    imem_rdata;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               if_valid;
    logic               if_ready;
    logic [ILEN-1:0]    if_instr;
    logic [XLEN-1:0]    if_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   num_checks = 0;
    int   num_fails  = 0;
    int   drain_cycles;

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Instruction memory model: word k holds the value 4k.
    assign imem_rdata = {{(ILEN-IMEM_AW-2){1'b0}}, imem_addr, 2'b00};

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .QDEPTH  (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic fe, input logic rdy,
                                 input logic rv, input logic [31:0] rpc);
        rst_n          = rst;
        fetch_en       = fe;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    // Hold reset for two edges; returns at posedge+1 with reset still low.
    task automatic resetDut(input logic rdy);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        if_ready = rdy;
    endtask

    // Wait (bounded) until every queued expectation was delivered, then
    // stop accepting so nothing further is popped.
    task automatic waitDrain(input string name, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 80) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if_ready = 1'b0;
        if (exp_q.size() != 0) begin
            num_checks++;
            num_fails++;
            $display("[TB] FAIL %s_timeout: got %0d entries undelivered, expected 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every completed handshake must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_valid === 1'b1 && if_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    num_checks++;
                    num_fails++;
                    $display("[TB] FAIL unexpected_pop: got pc %h, expected no delivery", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("deliver_pc", if_pc, e.pc);
                    checkOutput("deliver_instr", if_instr, e.instr);
                end
            end
        end
    end

    initial begin
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        // Streaming from reset with decode always ready.
        $display("[TB] scenario: stream");
        resetDut(1'b1);
        @(negedge clk);
        checkOutput("reset_valid", 32'(if_valid), 32'h0);
        checkOutput("reset_instr", if_instr, 32'h0);
        checkOutput("reset_pc", if_pc, 32'h0);
        checkOutput("reset_addr", 32'(imem_addr), 32'h0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) pushExp(32'(4 * k), 32'(4 * k));
        rst_n = 1'b1;
        waitDrain("stream", drain_cycles);
        checkOutput("stream_cycles", 32'(drain_cycles), 32'd17);

        // Backpressure: queue fills with PCs 0 and 4, PC stalls at 8.
        $display("[TB] scenario: backpressure");
        resetDut(1'b0);
        pushExp(32'h0, 32'h0);
        pushExp(32'h4, 32'h4);
        pushExp(32'h8, 32'h8);
        pushExp(32'hC, 32'hC);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("bp_valid", 32'(if_valid), 32'h1);
        checkOutput("bp_head_pc", if_pc, 32'h0);
        checkOutput("bp_head_instr", if_instr, 32'h0);
        checkOutput("bp_pc_stall", 32'(imem_addr), 32'h2);
        @(posedge clk);
        #1;
        if_ready = 1'b1;
        waitDrain("backpressure", drain_cycles);

        // Redirect while PC 12 is at the head.
        $display("[TB] scenario: redirect");
        resetDut(1'b1);
        pushExp(32'h0, 32'h0);
        pushExp(32'h4, 32'h4);
        pushExp(32'h8, 32'h8);
        pushExp(32'hC, 32'hC);
        pushExp(32'h20, 32'h20);
        pushExp(32'h24, 32'h24);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0023);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("redirect_bubble", 32'(if_valid), 32'h0);
        checkOutput("redirect_addr", 32'(imem_addr), 32'h8);
        waitDrain("redirect", drain_cycles);

        // Redirect with a pop while full, then fetch disabled for 3 cycles.
        $display("[TB] scenario: redirect_full_and_disable");
        resetDut(1'b0);
        pushExp(32'h0, 32'h0);
        pushExp(32'h100, 32'h100);
        pushExp(32'h104, 32'h104);
        pushExp(32'h108, 32'h108);
        pushExp(32'h10C, 32'h10C);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("flush_valid", 32'(if_valid), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("disabled_drained", 32'(if_valid), 32'h0);
        checkOutput("disabled_pc_held", 32'(imem_addr), 32'h42);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        waitDrain("disable", drain_cycles);

        // Synchronous reset with two entries (PC 4, 8) queued.
        $display("[TB] scenario: midstream_reset");
        resetDut(1'b1);
        pushExp(32'h0, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_valid", 32'(if_valid), 32'h1);
        checkOutput("mid_head_pc", if_pc, 32'h4);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_valid", 32'(if_valid), 32'h0);
        checkOutput("mid_rst_instr", if_instr, 32'h0);
        checkOutput("mid_rst_pc", if_pc, 32'h0);
        checkOutput("mid_rst_addr", 32'(imem_addr), 32'h0);
        pushExp(32'h0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        waitDrain("midreset", drain_cycles);

        // PC wrap through the top of the address space.
        $display("[TB] scenario: pc_wrap");
        resetDut(1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        pushExp(32'hFFFF_FFFC, 32'h0000_0FFC);
        pushExp(32'h0000_0000, 32'h0000_0000);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("wrap_addr_top", 32'(imem_addr), 32'h3FF);
        checkOutput("wrap_bubble", 32'(if_valid), 32'h0);
        @(negedge clk);
        checkOutput("wrap_addr_zero", 32'(imem_addr), 32'h0);
        waitDrain("wrap", drain_cycles);

        @(negedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
